noc_ni_tx: RTL and testbench

- NoC network-interface transmitter at the far end of the core's memory-mapped NoC registers (MMR window, base 4000).
- The core fills the registers with LOADNOC-style writes (destination and data) and triggers with a STORENOC-style write to the status word.
- The block snapshots the packet and serializes it as one head flit plus four payload flits on a valid/ready link.
- It reports completion through the status word, a busy level and a done pulse.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/noc_ni_regs.sv | 59 +++++
 rtl/noc_ni_tx.sv | 138 +++++++++++++
 tb/tb_noc_ni_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC network-interface transmitter.
// NOC_PARITY_EN advertises the parity capability through STATUS bit1.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_NONE = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } tx_state_e;

  // Byte offsets relative to the MMR window that starts at MMR_BASE.
  localparam int unsigned MMR_BASE   = 4000;
  localparam logic [4:0]  CTRL_OFF   = 5'h00;
  localparam logic [4:0]  DATA_OFF   = 5'h08;
  localparam logic [4:0]  STATUS_OFF = 5'h10;

`ifdef NOC_PARITY_EN
  localparam logic STATUS_PARITY_CAP = 1'b1;
`else
  localparam logic STATUS_PARITY_CAP = 1'b0;
`endif

  function automatic logic even_parity(input logic [9:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/noc_ni_regs.sv
// MMR decode, CTRL/DATA registers and combinational read mux for the NoC TX.
// STATUS bit1 reflects NOC_PARITY_EN through the package capability flag.
module noc_ni_regs
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mmr_we,
  input  logic [4:0]  mmr_addr,
  input  logic [31:0] mmr_wdata,
  input  logic        busy,
  output logic [31:0] mmr_rdata,
  output logic [3:0]  dest,
  output logic [31:0] data,
  output logic        start
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (mmr_we) begin
      case (mmr_addr)
        CTRL_OFF: ctrl_d = mmr_wdata[3:0];
        DATA_OFF: data_d = mmr_wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= 4'd0;
      data_q <= 32'd0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  // A START arriving while a packet is in flight is dropped, not queued.
  assign start = mmr_we && (mmr_addr == STATUS_OFF) && mmr_wdata[0] && !busy;

  always_comb begin
    mmr_rdata = 32'd0;
    case (mmr_addr)
      CTRL_OFF:   mmr_rdata = {28'd0, ctrl_q};
      DATA_OFF:   mmr_rdata = data_q;
      STATUS_OFF: mmr_rdata = {30'd0, STATUS_PARITY_CAP, busy};
      default:    mmr_rdata = 32'd0;
    endcase
  end

  assign dest = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/noc_ni_tx.sv
// NoC NI transmitter: snapshots dest/data on START and sends HEAD + 4 payload flits.
// Defining NOC_PARITY_EN adds the flit_parity output (even parity over type and data).
module noc_ni_tx
  import noc_pkg::*;
#(
  parameter int         FLIT_W = 8,
  parameter logic [3:0] SRC_ID = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mmr_we,
  input  logic [4:0]        mmr_addr,
  input  logic [31:0]       mmr_wdata,
  output logic [31:0]       mmr_rdata,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [FLIT_W-1:0] flit_data,
  output logic [1:0]        flit_type,
`ifdef NOC_PARITY_EN
  output logic              flit_parity,
`endif
  output logic              busy,
  output logic              irq_done
);

  logic [3:0]  reg_dest;
  logic [31:0] reg_data;
  logic        start;

  tx_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, cnt_nxt;
  logic [31:0]       shift_q, shift_d;
  logic [FLIT_W-1:0] flit_data_q, flit_data_d;
  flit_type_e        flit_type_q, flit_type_d;
  logic              flit_valid_q, flit_valid_d;
  logic              busy_q, busy_d;
  logic              irq_done_q, irq_done_d;
  logic              hs;

  noc_ni_regs u_regs (
    .clk       (clk),
    .reset     (reset),
    .mmr_we    (mmr_we),
    .mmr_addr  (mmr_addr),
    .mmr_wdata (mmr_wdata),
    .busy      (busy_q),
    .mmr_rdata (mmr_rdata),
    .dest      (reg_dest),
    .data      (reg_data),
    .start     (start)
  );

  assign hs      = flit_valid_q & flit_ready;
  assign cnt_nxt = cnt_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    flit_data_d  = flit_data_q;
    flit_type_d  = flit_type_q;
    flit_valid_d = flit_valid_q;
    busy_d       = busy_q;
    irq_done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_HEAD;
          shift_d      = reg_data;
          flit_data_d  = {reg_dest, SRC_ID};
          flit_type_d  = FLIT_HEAD;
          flit_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_HEAD: begin
        if (hs) begin
          state_d     = ST_BODY;
          cnt_d       = 2'd0;
          flit_data_d = shift_q[7:0];
          flit_type_d = FLIT_BODY;
        end
      end
      ST_BODY: begin
        if (hs) begin
          if (cnt_q == 2'd3) begin
            state_d      = ST_IDLE;
            cnt_d        = 2'd0;
            flit_data_d  = '0;
            flit_type_d  = FLIT_NONE;
            flit_valid_d = 1'b0;
            busy_d       = 1'b0;
            irq_done_d   = 1'b1;
          end else begin
            // Payload goes out least-significant byte first; last byte is TAIL.
            cnt_d       = cnt_nxt;
            flit_data_d = shift_q[{cnt_nxt, 3'b000} +: 8];
            flit_type_d = (cnt_nxt == 2'd3) ? FLIT_TAIL : FLIT_BODY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      shift_q      <= 32'd0;
      flit_data_q  <= '0;
      flit_type_q  <= FLIT_NONE;
      flit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      irq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      flit_data_q  <= flit_data_d;
      flit_type_q  <= flit_type_d;
      flit_valid_q <= flit_valid_d;
      busy_q       <= busy_d;
      irq_done_q   <= irq_done_d;
    end
  end

  assign flit_valid = flit_valid_q;
  assign flit_data  = flit_data_q;
  assign flit_type  = flit_type_q;
  assign busy       = busy_q;
  assign irq_done   = irq_done_q;

`ifdef NOC_PARITY_EN
  assign flit_parity = flit_valid_q & even_parity({flit_type_q, flit_data_q});
`endif

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed testbench for noc_ni_tx with a flit scoreboard; honours NOC_PARITY_EN.
module tb_noc_ni_tx;

  logic        clk;
  logic        reset;
  logic        mmr_we;
  logic [4:0]  mmr_addr;
  logic [31:0] mmr_wdata;
  logic [31:0] mmr_rdata;
  logic        flit_valid;
  logic        flit_ready;
  logic [7:0]  flit_data;
  logic [1:0]  flit_type;
  logic        busy;
  logic        irq_done;
`ifdef NOC_PARITY_EN
  logic        flit_parity;
  localparam logic [31:0] STATUS_IDLE = 32'h2;
`else
  localparam logic [31:0] STATUS_IDLE = 32'h0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int busy_cycles  = 0;
  int irq_cycles   = 0;
  logic [9:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [9:0] prev_flit  = 10'd0;

  noc_ni_tx #(.FLIT_W(8), .SRC_ID(4'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .mmr_we     (mmr_we),
    .mmr_addr   (mmr_addr),
    .mmr_wdata  (mmr_wdata),
    .mmr_rdata  (mmr_rdata),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .flit_type  (flit_type),
`ifdef NOC_PARITY_EN
    .flit_parity(flit_parity),
`endif
    .busy       (busy),
    .irq_done   (irq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] wdata);
    mmr_we    = 1'b1;
    mmr_addr  = addr;
    mmr_wdata = wdata;
    waitCycle();
    mmr_we    = 1'b0;
    mmr_wdata = 32'd0;
  endtask

  task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    mmr_addr = addr;
    #1;
    checkOutput(tag, mmr_rdata, exp);
  endtask

  task automatic pushPacket(input logic [3:0] dest, input logic [31:0] data);
    exp_q.push_back({2'b01, dest, 4'h0});
    for (int i = 0; i < 4; i++)
      exp_q.push_back({(i == 3) ? 2'b11 : 2'b10, data[8*i +: 8]});
  endtask

  task automatic waitIrq(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (irq_done) begin
        found = 1'b1;
        break;
      end
      waitCycle();
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic clearCounters();
    valid_cycles = 0;
    busy_cycles  = 0;
    irq_cycles   = 0;
  endtask

  // Link monitor: pops the scoreboard on every handshake and checks stalled flits hold.
  always @(negedge clk) begin
    logic [9:0] exp;
    if (!reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (flit_valid) valid_cycles++;
      if (busy)       busy_cycles++;
      if (irq_done)   irq_cycles++;
      if (flit_valid && prev_valid && !prev_hs)
        checkOutput("hold", {22'd0, flit_type, flit_data}, {22'd0, prev_flit});
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_flit", {22'd0, flit_type, flit_data}, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("flit", {22'd0, flit_type, flit_data}, {22'd0, exp});
`ifdef NOC_PARITY_EN
          checkOutput("parity", 32'(flit_parity), 32'(^exp));
`endif
        end
      end
      prev_valid = flit_valid;
      prev_hs    = flit_valid && flit_ready;
      prev_flit  = {flit_type, flit_data};
    end
  end

  initial begin
    reset      = 1'b0;
    mmr_we     = 1'b0;
    mmr_addr   = 5'd0;
    mmr_wdata  = 32'd0;
    flit_ready = 1'b0;
    repeat (2) waitCycle();

    checkOutput("rst_valid", 32'(flit_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_irq", 32'(irq_done), 32'd0);
    checkOutput("rst_flit", {22'd0, flit_type, flit_data}, 32'd0);
    checkReg("rst_status", 5'h10, STATUS_IDLE);
`ifdef NOC_PARITY_EN
    checkOutput("rst_parity", 32'(flit_parity), 32'd0);
`endif
    reset = 1'b1;
    waitCycle();

    $display("[TB] basic packet");
    applyStimulus(5'h00, 32'd5);
    applyStimulus(5'h08, 32'hA1B2C3D4);
    flit_ready = 1'b1;
    clearCounters();
    pushPacket(4'd5, 32'hA1B2C3D4);
    applyStimulus(5'h10, 32'd1);
    checkOutput("start_valid", 32'(flit_valid), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    waitIrq("basic_irq", 40);
    checkReg("basic_status", 5'h10, STATUS_IDLE);
    checkOutput("basic_busy_low", 32'(busy), 32'd0);
    waitCycle();
    checkOutput("irq_one_cycle", 32'(irq_done), 32'd0);
    checkOutput("basic_valid_cycles", 32'(valid_cycles), 32'd5);
    checkOutput("basic_busy_cycles", 32'(busy_cycles), 32'd5);
    checkOutput("basic_irq_cycles", 32'(irq_cycles), 32'd1);
    checkOutput("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] backpressure");
    flit_ready = 1'b0;
    clearCounters();
    pushPacket(4'd5, 32'hA1B2C3D4);
    applyStimulus(5'h10, 32'd1);
    repeat (3) waitCycle();
    flit_ready = 1'b1;
    repeat (3) waitCycle();
    flit_ready = 1'b0;
    checkOutput("bp_byte2", {22'd0, flit_type, flit_data}, {22'd0, 2'b10, 8'hB2});
    repeat (2) waitCycle();
    checkOutput("bp_byte2_held", {22'd0, flit_type, flit_data}, {22'd0, 2'b10, 8'hB2});
    flit_ready = 1'b1;
    waitIrq("bp_irq", 40);
    waitCycle();
    checkOutput("bp_valid_cycles", 32'(valid_cycles), 32'd10);
    checkOutput("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] START while busy with DATA rewrite");
    flit_ready = 1'b0;
    clearCounters();
    pushPacket(4'd5, 32'hA1B2C3D4);
    applyStimulus(5'h10, 32'd1);
    applyStimulus(5'h08, 32'h11223344);
    applyStimulus(5'h10, 32'd1);
    flit_ready = 1'b1;
    waitIrq("busy_start_irq", 40);
    repeat (3) waitCycle();
    checkOutput("no_second_pkt", 32'(flit_valid), 32'd0);
    checkOutput("busy_start_valid_cycles", 32'(valid_cycles), 32'd7);
    checkReg("data_updated", 5'h08, 32'h11223344);

    clearCounters();
    pushPacket(4'd5, 32'h11223344);
    applyStimulus(5'h10, 32'd1);
    applyStimulus(5'h00, 32'd10);
    waitIrq("new_data_irq", 40);
    waitCycle();
    pushPacket(4'd10, 32'h11223344);
    applyStimulus(5'h10, 32'd1);
    checkOutput("b2b_start", 32'(flit_valid), 32'd1);
    waitIrq("b2b_irq", 40);
    waitCycle();
    checkOutput("b2b_valid_cycles", 32'(valid_cycles), 32'd10);
    checkOutput("b2b_irq_cycles", 32'(irq_cycles), 32'd2);
    checkOutput("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] async reset mid-packet");
    clearCounters();
    pushPacket(4'd10, 32'h11223344);
    applyStimulus(5'h10, 32'd1);
    repeat (2) waitCycle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", 32'(flit_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_irq", 32'(irq_done), 32'd0);
    checkOutput("abort_flit", {22'd0, flit_type, flit_data}, 32'd0);
    exp_q.delete();
    repeat (2) waitCycle();
    reset = 1'b1;
    waitCycle();
    checkReg("post_rst_ctrl", 5'h00, 32'd0);
    checkReg("post_rst_data", 5'h08, 32'd0);
    checkReg("post_rst_status", 5'h10, STATUS_IDLE);
    repeat (3) waitCycle();
    checkOutput("abort_no_irq", 32'(irq_cycles), 32'd0);
    checkOutput("abort_idle", 32'(flit_valid), 32'd0);

    $display("[TB] address decode");
    applyStimulus(5'h00, 32'd3);
    applyStimulus(5'h08, 32'h00000055);
    applyStimulus(5'h04, 32'hFFFFFFFF);
    checkReg("unmapped_read", 5'h04, 32'd0);
    checkReg("ctrl_kept", 5'h00, 32'd3);
    checkReg("data_kept", 5'h08, 32'h00000055);
    checkReg("status_idle", 5'h10, STATUS_IDLE);
    clearCounters();
    applyStimulus(5'h10, 32'hFFFFFFFE);
    repeat (3) waitCycle();
    checkOutput("no_start_bit0_clear", 32'(valid_cycles), 32'd0);
    checkOutput("no_start_busy", 32'(busy), 32'd0);
`ifdef NOC_PARITY_EN
    checkOutput("idle_parity", 32'(flit_parity), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
